xcorr_frame_sequencer: RTL and testbench
========================================

// Module: xcorr_frame_sequencer
// PURPOSE
//  Sequencing controller for binary cross-correlation. Accepts frame pairs (in1, in2) over valid/ready
//  and evaluates one lag per cycle on a single shared product/sum unit. Integrates each lag over
//  NFRAMES frames, then drains the lag results serially over valid/ready. Sits between the sample
//  framer and the detection logic; replaces free-running all-lags-per-clock correlation.
// PARAMETERS
//  LEN      3   bits per frame; number of lags NLAG = 2*LEN-1
//  ACC_W    8   width of each lag accumulator and of out_data (saturating)
//  NFRAMES  4   frames integrated per result set (>=1)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  frame pair offered
//  in_ready   out  1                  frame pair accepted when in_valid & in_ready
//  in1        in   LEN                frame from channel 1
//  in2        in   LEN                frame from channel 2
//  out_valid  out  1                  result word valid
//  out_ready  in   1                  consumer accepts word when out_valid & out_ready
//  out_lag    out  $clog2(NLAG)       lag index k of out_data, 0..NLAG-1
//  out_data   out  ACC_W              integrated correlation for lag k
//  out_last   out  1                  high with k = NLAG-1
//  busy       out  1                  high whenever state != IDLE
// BEHAVIOUR
//  - Lag k, d = k-(LEN-1): c[k] = sum over y=0..LEN-1-|d| of in1[y+max(d,0)] & in2[y+max(-d,0)].
//    k=0 -> in1[0]&in2[LEN-1]; k=NLAG-1 -> in1[LEN-1]&in2[0]; k=LEN-1 -> popcount(in1&in2).
//  - FSM IDLE -> COMPUTE -> (IDLE | DRAIN) -> IDLE.
//  - IDLE: in_ready=1. On in_valid: register in1/in2, lag_idx=0, go COMPUTE.
//  - COMPUTE: in_ready=0; for exactly NLAG cycles, cycle j: acc[j] <= sat(acc[j]+c[j]).
//    After lag NLAG-1: if frame_cnt==NFRAMES-1 go DRAIN, frame_cnt=0; else frame_cnt++, go IDLE.
//  - Throughput: one frame per NLAG+1 cycles. in_ready re-asserts the cycle after the last COMPUTE
//    cycle. Input frames are never dropped; in1/in2 changes outside acceptance are ignored.
//  - DRAIN: out_valid=1, out_lag=drain_idx, out_data=acc[drain_idx]. On out_ready: drain_idx++.
//    First out_valid is the cycle after the final COMPUTE cycle.
//    On acceptance with out_last=1: clear all acc to 0, drain_idx=0, go IDLE (in_ready next cycle).
//  - out_valid low: out_data/out_lag/out_last are 0. out_valid high: held stable until accepted.
//  - Saturation: sum clamps at 2^ACC_W-1, no wrap; other lags unaffected.
//  - NFRAMES=1: every frame goes COMPUTE -> DRAIN.
//  - Reset, incl. mid-COMPUTE/mid-DRAIN: state=IDLE, all acc=0, frame_cnt=0, lag/drain idx=0,
//    in_ready=1, out_valid=0, out_lag=0, out_data=0, out_last=0, busy=0. Partial sums discarded.
// TESTING
//  1 LEN=3,NFRAMES=4, 4 frames in1=111 in2=111 -> drain lags 0..4 = 4,8,12,8,4; out_last on lag 4.
//  2 NFRAMES=1, in1=001 in2=100 -> 1,0,0,0,0; in1=100 in2=001 -> 0,0,0,0,1.
//  3 ACC_W=3,NFRAMES=4, in1=in2=111 x4 -> 4,7,7,7,4 (saturated, no wrap).
//  4 in_valid held high continuously -> in_ready pulses once per 6 cycles in COMPUTE phases;
//    exactly NFRAMES frames consumed per result set; none lost or duplicated.
//  5 out_ready low 10 cycles on lag 2 -> out_lag=2, out_data stable; resume -> lags 3,4, then IDLE.
//  6 rst pulsed during DRAIN lag 1 -> next cycle all outputs reset values; new 4-frame set
//    in1=in2=111 drains 4,8,12,8,4 (no residue).

Source files
------------

// File: rtl/xcorr_frame_sequencer_if.sv
// rtl/xcorr_frame_sequencer_if.sv - frame-pair input and lag-result output handshakes
interface xcorr_frame_sequencer_if #(
    parameter int LEN   = 3,
    parameter int ACC_W = 8
);
    localparam int NLAG  = 2 * LEN - 1;
    localparam int LAG_W = (NLAG > 1) ? $clog2(NLAG) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [LEN-1:0]   in1;
    logic [LEN-1:0]   in2;
    logic             out_valid;
    logic             out_ready;
    logic [LAG_W-1:0] out_lag;
    logic [ACC_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out_lag, out_data, out_last
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out_lag, out_data, out_last
    );
endinterface

// File: rtl/xcorr_frame_sequencer.sv
// rtl/xcorr_frame_sequencer.sv - time-shared binary cross-correlator, one lag per cycle
// Integrates NFRAMES frame pairs per lag, then drains the lag accumulators serially.
module xcorr_frame_sequencer #(
    parameter int LEN     = 3,
    parameter int ACC_W   = 8,
    parameter int NFRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    xcorr_frame_sequencer_if.slave   bus,
    output logic                     busy
);
    localparam int NLAG  = 2 * LEN - 1;
    localparam int LAG_W = (NLAG > 1) ? $clog2(NLAG) : 1;
    localparam int FRM_W = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int CW    = $clog2(LEN + 1);
    localparam int SW    = ((ACC_W > CW) ? ACC_W : CW) + 1;

    localparam logic [LAG_W-1:0] LAST_LAG   = LAG_W'(NLAG - 1);
    localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(NFRAMES - 1);
    localparam logic [SW-1:0]    ACC_MAX    = SW'({ACC_W{1'b1}});

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

    state_t           state;
    logic [LEN-1:0]   in1_r;
    logic [LEN-1:0]   in2_r;
    logic [LAG_W-1:0] lag_idx;
    logic [LAG_W-1:0] drain_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic [ACC_W-1:0] acc [NLAG];

    logic             in_ready_r;
    logic             out_valid_r;
    logic [LAG_W-1:0] out_lag_r;
    logic [ACC_W-1:0] out_data_r;
    logic             out_last_r;
    logic             busy_r;

    // Number of coincident ones when in2 is shifted by d = k-(LEN-1) against in1.
    function automatic logic [CW-1:0] lag_corr(input logic [LEN-1:0] a,
                                               input logic [LEN-1:0] b,
                                               input logic [LAG_W-1:0] k);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LEN; i++) begin
            for (int j = 0; j < LEN; j++) begin
                if (i - j == int'(k) - (LEN - 1)) begin
                    cnt = cnt + CW'(a[i] & b[j]);
                end
            end
        end
        return cnt;
    endfunction

    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] acc_upd;
    logic [LAG_W-1:0] drain_nxt;

    assign sum       = SW'(acc[lag_idx]) + SW'(lag_corr(in1_r, in2_r, lag_idx));
    assign acc_upd   = (sum > ACC_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign drain_nxt = drain_idx + LAG_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in1_r       <= '0;
            in2_r       <= '0;
            lag_idx     <= '0;
            drain_idx   <= '0;
            frame_cnt   <= '0;
            for (int i = 0; i < NLAG; i++) acc[i] <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_lag_r   <= '0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in1_r      <= bus.in1;
                        in2_r      <= bus.in2;
                        lag_idx    <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc[lag_idx] <= acc_upd;
                    if (lag_idx == LAST_LAG) begin
                        lag_idx <= '0;
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt   <= '0;
                            drain_idx   <= '0;
                            out_valid_r <= 1'b1;
                            out_lag_r   <= '0;
                            // With a single lag, lag 0 is being written this very cycle.
                            out_data_r  <= (LAST_LAG == '0) ? acc_upd : acc[0];
                            out_last_r  <= (LAST_LAG == '0);
                            state       <= DRAIN;
                        end else begin
                            frame_cnt  <= frame_cnt + FRM_W'(1);
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        lag_idx <= lag_idx + LAG_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (drain_idx == LAST_LAG) begin
                            for (int i = 0; i < NLAG; i++) acc[i] <= '0;
                            drain_idx   <= '0;
                            out_valid_r <= 1'b0;
                            out_lag_r   <= '0;
                            out_data_r  <= '0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            drain_idx  <= drain_nxt;
                            out_lag_r  <= drain_nxt;
                            out_data_r <= acc[drain_nxt];
                            out_last_r <= (drain_nxt == LAST_LAG);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_lag   = out_lag_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_xcorr_frame_sequencer.sv
// tb/tb_xcorr_frame_sequencer.sv - randomized self-checking bench for xcorr_frame_sequencer
module tb_xcorr_frame_sequencer;
    localparam int LEN  = 3;
    localparam int NLAG = 2 * LEN - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     sel = 2'd0;
    logic           in_valid = 1'b0;
    logic [LEN-1:0] in1 = '0;
    logic [LEN-1:0] in2 = '0;
    logic           out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int maxv = 255;
    int exp_acc [NLAG];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xcorr_frame_sequencer_if #(.LEN(LEN), .ACC_W(8)) bus_a ();
    xcorr_frame_sequencer_if #(.LEN(LEN), .ACC_W(8)) bus_b ();
    xcorr_frame_sequencer_if #(.LEN(LEN), .ACC_W(3)) bus_c ();
    logic busy_a, busy_b, busy_c;

    assign bus_a.in_valid  = in_valid && (sel == 2'd0);
    assign bus_b.in_valid  = in_valid && (sel == 2'd1);
    assign bus_c.in_valid  = in_valid && (sel == 2'd2);
    assign bus_a.in1 = in1;
    assign bus_a.in2 = in2;
    assign bus_b.in1 = in1;
    assign bus_b.in2 = in2;
    assign bus_c.in1 = in1;
    assign bus_c.in2 = in2;
    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;
    assign bus_c.out_ready = out_ready;

    xcorr_frame_sequencer #(.LEN(LEN), .ACC_W(8), .NFRAMES(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a));
    xcorr_frame_sequencer #(.LEN(LEN), .ACC_W(8), .NFRAMES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b));
    xcorr_frame_sequencer #(.LEN(LEN), .ACC_W(3), .NFRAMES(4)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave), .busy(busy_c));

    logic       m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [2:0] m_out_lag;
    logic [7:0] m_out_data;

    always_comb begin
        m_in_ready  = bus_a.in_ready;
        m_out_valid = bus_a.out_valid;
        m_out_last  = bus_a.out_last;
        m_out_lag   = bus_a.out_lag;
        m_out_data  = bus_a.out_data;
        m_busy      = busy_a;
        if (sel == 2'd1) begin
            m_in_ready  = bus_b.in_ready;
            m_out_valid = bus_b.out_valid;
            m_out_last  = bus_b.out_last;
            m_out_lag   = bus_b.out_lag;
            m_out_data  = bus_b.out_data;
            m_busy      = busy_b;
        end else if (sel == 2'd2) begin
            m_in_ready  = bus_c.in_ready;
            m_out_valid = bus_c.out_valid;
            m_out_last  = bus_c.out_last;
            m_out_lag   = bus_c.out_lag;
            m_out_data  = {5'b0, bus_c.out_data};
            m_busy      = busy_c;
        end
    end

    function automatic int ref_lag(input logic [LEN-1:0] a, input logic [LEN-1:0] b, input int k);
        int d  = k - (LEN - 1);
        int o1 = (d > 0) ? d : 0;
        int o2 = (d < 0) ? -d : 0;
        int ad = (d < 0) ? -d : d;
        int s  = 0;
        for (int y = 0; y <= LEN - 1 - ad; y++) s += int'(a[y + o1] & b[y + o2]);
        return s;
    endfunction

    task automatic model_add(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        for (int k = 0; k < NLAG; k++) begin
            exp_acc[k] += ref_lag(a, b, k);
            if (exp_acc[k] > maxv) exp_acc[k] = maxv;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NLAG; k++) exp_acc[k] = 0;
    endtask

    task automatic send_frame(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        int n = 0;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!m_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", m_in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_add(a, b);
    endtask

    // Must be entered just after a rising edge so that no word is consumed unseen.
    task automatic drain_check(input string name, input int stall_lag);
        int n;
        for (int k = 0; k < NLAG; k++) begin
            out_ready = (k != stall_lag);
            n = 0;
            @(negedge clk);
            while (!m_out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (m_out_valid !== 1'b1 || m_out_lag !== 3'(k) || m_out_data !== 8'(exp_acc[k])
                || m_out_last !== (k == NLAG - 1)) begin
                errors++;
                $display("FAIL %s lag%0d: valid=%b lag=%0d data=%0d last=%b required valid=1 lag=%0d data=%0d last=%b",
                         name, k, m_out_valid, m_out_lag, m_out_data, m_out_last, k, exp_acc[k], (k == NLAG - 1));
            end
            if (k == stall_lag) begin
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    checks++;
                    if (m_out_valid !== 1'b1 || m_out_lag !== 3'(k) || m_out_data !== 8'(exp_acc[k])) begin
                        errors++;
                        $display("FAIL %s stall%0d: valid=%b lag=%0d data=%0d required valid=1 lag=%0d data=%0d",
                                 name, s, m_out_valid, m_out_lag, m_out_data, k, exp_acc[k]);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_busy !== 1'b0 || m_out_data !== 8'd0
            || m_out_last !== 1'b0 || m_out_lag !== 3'd0) begin
            errors++;
            $display("FAIL %s_idle: valid=%b ready=%b busy=%b data=%0d last=%b lag=%0d required 0 1 0 0 0 0",
                     name, m_out_valid, m_in_ready, m_busy, m_out_data, m_out_last, m_out_lag);
        end
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_a.in_ready, bus_a.out_valid, bus_a.out_last, busy_a} !== 4'b1000
            || bus_a.out_data !== 8'd0 || bus_a.out_lag !== 3'd0) begin
            errors++;
            $display("FAIL reset_a: rdy/vld/last/busy=%b data=%0d lag=%0d required 1000 0 0",
                     {bus_a.in_ready, bus_a.out_valid, bus_a.out_last, busy_a}, bus_a.out_data, bus_a.out_lag);
        end
        checks++;
        if ({bus_b.in_ready, bus_b.out_valid, bus_b.out_last, busy_b} !== 4'b1000
            || {bus_c.in_ready, bus_c.out_valid, bus_c.out_last, busy_c} !== 4'b1000
            || bus_b.out_data !== 8'd0 || bus_c.out_data !== 3'd0) begin
            errors++;
            $display("FAIL reset_bc: b=%b c=%b required 1000 1000",
                     {bus_b.in_ready, bus_b.out_valid, bus_b.out_last, busy_b},
                     {bus_c.in_ready, bus_c.out_valid, bus_c.out_last, busy_c});
        end
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_ones();
        int n = 0;
        int bad = 0;
        sel = 2'd0;
        maxv = 255;
        repeat (4) send_frame(3'b111, 3'b111);
        @(negedge clk);
        while (!m_out_valid && n < 50) begin
            if (m_busy !== 1'b1 || m_in_ready !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== NLAG) begin
            errors++;
            $display("FAIL drain_latency: cycles=%0d required %0d", n, NLAG);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL compute_flags: bad_cycles=%0d required 0", bad);
        end
        @(posedge clk);
        #1;
        drain_check("all_ones", -1);
    endtask

    task automatic test_nframes_one();
        sel = 2'd1;
        maxv = 255;
        send_frame(3'b001, 3'b100);
        drain_check("nf1_lead", -1);
        send_frame(3'b100, 3'b001);
        drain_check("nf1_lag", -1);
        repeat (3) begin
            send_frame(3'($urandom), 3'($urandom));
            drain_check("nf1_rand", -1);
        end
        sel = 2'd0;
    endtask

    task automatic test_saturation();
        sel = 2'd2;
        maxv = 7;
        repeat (4) send_frame(3'b111, 3'b111);
        drain_check("sat_ones", -1);
        repeat (4) send_frame(3'($urandom), 3'($urandom));
        drain_check("sat_rand", -1);
        sel = 2'd0;
        maxv = 255;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int got = 0;
        int last = -1;
        int extra = 0;
        sel = 2'd0;
        in1 = 3'($urandom);
        in2 = 3'($urandom);
        in_valid = 1'b1;
        while (got < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (m_in_ready) begin
                model_add(in1, in2);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== NLAG + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing: cycles=%0d required %0d", cyc - last, NLAG + 1);
                    end
                end
                last = cyc;
                got++;
                @(posedge clk);
                #1;
                in1 = 3'($urandom);
                in2 = 3'($urandom);
            end
        end
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d required 4", got);
        end
        repeat (20) begin
            @(negedge clk);
            if (m_in_ready !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL b2b_overrun: ready_cycles=%0d required 0", extra);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain_check("b2b", -1);
    endtask

    task automatic test_backpressure();
        sel = 2'd0;
        repeat (4) send_frame(3'($urandom), 3'($urandom));
        drain_check("stall", 2);
    endtask

    task automatic test_random();
        int st;
        sel = 2'd0;
        repeat (3) begin
            repeat (4) send_frame(3'($urandom), 3'($urandom));
            st = int'($urandom_range(0, NLAG));
            drain_check("random", (st == NLAG) ? -1 : st);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        sel = 2'd0;
        send_frame(3'b111, 3'b111);
        send_frame(3'b101, 3'b011);
        send_frame(3'($urandom), 3'($urandom));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_in_ready !== 1'b1 || m_busy !== 1'b0 || m_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_compute: ready=%b busy=%b valid=%b required 1 0 0", m_in_ready, m_busy, m_out_valid);
        end
        model_clear();
        @(posedge clk);
        #1;
        repeat (4) send_frame(3'b111, 3'b111);
        out_ready = 1'b1;
        @(negedge clk);
        while (!(m_out_valid && m_out_lag == 3'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_a.in_ready, bus_a.out_valid, bus_a.out_last, busy_a} !== 4'b1000
            || bus_a.out_data !== 8'd0 || bus_a.out_lag !== 3'd0) begin
            errors++;
            $display("FAIL reset_drain: rdy/vld/last/busy=%b data=%0d lag=%0d required 1000 0 0",
                     {bus_a.in_ready, bus_a.out_valid, bus_a.out_last, busy_a}, bus_a.out_data, bus_a.out_lag);
        end
        model_clear();
        @(posedge clk);
        #1;
        repeat (4) send_frame(3'b111, 3'b111);
        drain_check("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_nframes_one();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
